// File: rtl/ro_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : ro_freq_meter
//  Description : Gated edge counter. Counts rising edges of an asynchronous
//                ring-oscillator-derived signal over a fixed window of
//                GATE_CYCLES ICE_CLK cycles. Reports a saturating count and
//                an overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_freq_meter #(
    parameter int unsigned GATE_CYCLES = 12000000,
    parameter int unsigned COUNT_W     = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               ICE_CLK,
    input  logic               rst,
    input  logic               ro_div,
    input  logic               start,
    input  logic               continuous,
    input  logic               abort,
    output logic               busy,
    output logic [COUNT_W-1:0] result,
    output logic               result_valid,
    output logic               overflow
);

    // A window of N cycles needs a down-counter that holds N-1; one bit minimum.
    localparam int unsigned c_GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned c_ARM_W  = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

    localparam logic [c_GATE_W-1:0] c_GATE_LOAD = c_GATE_W'(GATE_CYCLES - 1);
    localparam logic [c_ARM_W-1:0]  c_ARM_LOAD  = c_ARM_W'(SYNC_STAGES - 1);
    localparam logic [COUNT_W-1:0]  c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_prev;
    logic [c_ARM_W-1:0]   r_arm;
    logic [c_GATE_W-1:0]  r_gate;
    logic [COUNT_W-1:0]   r_cnt;
    logic                 r_ovf;
    logic [COUNT_W-1:0]   r_result;
    logic                 r_result_valid;
    logic                 r_overflow;

    logic                 w_rise;
    logic                 w_sat;
    logic [COUNT_W-1:0]   w_cnt_inc;
    logic                 w_ovf_inc;

    // Synchroniser chain for ro_div followed by the edge-detect history flop.
    always_ff @(posedge ICE_CLK or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ro_div};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Count value and overflow flag after including this cycle's rise.
    assign w_sat     = (r_cnt == c_CNT_MAX);
    assign w_cnt_inc = (w_rise && !w_sat) ? r_cnt + 1'b1 : r_cnt;
    assign w_ovf_inc = r_ovf | (w_rise & w_sat);

    // State register.
    always_ff @(posedge ICE_CLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort dominates completion, restart and start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_arm == '0) begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_gate == '0) begin
                    w_state_next = continuous ? ST_MEASURE : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Arm/gate/edge counters and the result registers.
    always_ff @(posedge ICE_CLK or posedge rst) begin
        if (rst) begin
            r_arm          <= '0;
            r_gate         <= '0;
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_arm <= c_ARM_LOAD;
                    end
                end
                ST_ARM: begin
                    if (!abort) begin
                        if (r_arm == '0) begin
                            r_gate <= c_GATE_LOAD;
                            r_cnt  <= '0;
                            r_ovf  <= 1'b0;
                        end else begin
                            r_arm <= r_arm - 1'b1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (!abort) begin
                        if (r_gate == '0) begin
                            // Final window cycle: publish, then reload so a
                            // continuous restart tiles with no gap.
                            r_result       <= w_cnt_inc;
                            r_overflow     <= w_ovf_inc;
                            r_result_valid <= 1'b1;
                            r_gate         <= c_GATE_LOAD;
                            r_cnt          <= '0;
                            r_ovf          <= 1'b0;
                        end else begin
                            r_gate <= r_gate - 1'b1;
                            r_cnt  <= w_cnt_inc;
                            r_ovf  <= w_ovf_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ro_freq_meter
//  Description : Scoreboard bench for ro_freq_meter. Four instances with
//                different parameters share clock, reset and ro_div.
//                Index 0: GATE=100/W=24, 1: GATE=100/W=4, 2: GATE=50/W=24,
//                3: GATE=1/W=24.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_freq_meter;

    typedef struct packed {
        logic [1:0]  dut;
        logic [23:0] res;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ro_div;
    logic        continuous;
    logic        abort;
    logic [3:0]  start_v;
    logic [3:0]  busy_v;
    logic [3:0]  rv_v;
    logic [3:0]  ovf_v;
    logic [23:0] res_a;
    logic [3:0]  res_b;
    logic [23:0] res_c;
    logic [23:0] res_d;

    int   ro_period;
    logic manual;
    int   gen_ph;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];

    ro_freq_meter #(.GATE_CYCLES(100), .COUNT_W(24), .SYNC_STAGES(2)) u_a (
        .ICE_CLK(clk), .rst(rst), .ro_div(ro_div), .start(start_v[0]),
        .continuous(continuous), .abort(abort), .busy(busy_v[0]),
        .result(res_a), .result_valid(rv_v[0]), .overflow(ovf_v[0]));

    ro_freq_meter #(.GATE_CYCLES(100), .COUNT_W(4), .SYNC_STAGES(2)) u_b (
        .ICE_CLK(clk), .rst(rst), .ro_div(ro_div), .start(start_v[1]),
        .continuous(continuous), .abort(abort), .busy(busy_v[1]),
        .result(res_b), .result_valid(rv_v[1]), .overflow(ovf_v[1]));

    ro_freq_meter #(.GATE_CYCLES(50), .COUNT_W(24), .SYNC_STAGES(2)) u_c (
        .ICE_CLK(clk), .rst(rst), .ro_div(ro_div), .start(start_v[2]),
        .continuous(continuous), .abort(abort), .busy(busy_v[2]),
        .result(res_c), .result_valid(rv_v[2]), .overflow(ovf_v[2]));

    ro_freq_meter #(.GATE_CYCLES(1), .COUNT_W(24), .SYNC_STAGES(2)) u_d (
        .ICE_CLK(clk), .rst(rst), .ro_div(ro_div), .start(start_v[3]),
        .continuous(continuous), .abort(abort), .busy(busy_v[3]),
        .result(res_d), .result_valid(rv_v[3]), .overflow(ovf_v[3]));

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ro_div source: square wave of ro_period cycles, static low, or manual.
    initial begin
        ro_div = 1'b0;
        gen_ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (ro_period > 0) begin
                ro_div = ((gen_ph % ro_period) < (ro_period / 2));
                gen_ph++;
            end else if (ro_period < 0) begin
                ro_div = manual;
            end else begin
                ro_div = 1'b0;
            end
        end
    end

    function automatic logic [23:0] res_of(int d);
        case (d)
            0: return res_a;
            1: return {20'd0, res_b};
            2: return res_c;
            default: return res_d;
        endcase
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int d);
        @(posedge clk);
        #1;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
    endtask

    // Waits for result_valid of instance d; reports negedges waited (inclusive)
    // and how many of them had busy high.
    task automatic wait_valid(int d, int max, output int ncyc, output int nbusy);
        ncyc  = 0;
        nbusy = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (busy_v[d]) nbusy++;
            if (rv_v[d]) break;
            if (ncyc >= max) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout dut%0d: got no result_valid in %0d cycles, expected one", d, max);
                break;
            end
        end
    endtask

    task automatic count_valid(int d, int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (rv_v[d]) cnt++;
        end
    endtask

    initial begin
        int c, b, v;
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        continuous = 1'b0;
        abort      = 1'b0;
        start_v    = 4'b0;
        ro_period  = 0;
        manual     = 1'b0;
        fork
            // Monitor: every result_valid pops the next expected result.
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    for (int d = 0; d < 4; d++) begin
                        if (rv_v[d]) begin
                            n_cmp++;
                            if (exp_q.size() == 0) begin
                                n_err++;
                                $display("FAIL result dut%0d: got unexpected res=%0d ovf=%0d, expected no result", d, res_of(d), ovf_v[d]);
                            end else begin
                                e = exp_q.pop_front();
                                if (e.dut != 2'(d) || e.res != res_of(d) || e.ovf != ovf_v[d]) begin
                                    n_err++;
                                    $display("FAIL result dut%0d: got res=%0d ovf=%0d, expected dut%0d res=%0d ovf=%0d",
                                             d, res_of(d), ovf_v[d], e.dut, e.res, e.ovf);
                                end
                            end
                        end
                    end
                end
            end
            // Stimulus.
            begin
                // Reset state.
                repeat (3) @(negedge clk);
                check("reset busy", {28'd0, busy_v}, 32'd0);
                check("reset valid", {28'd0, rv_v}, 32'd0);
                check("reset overflow", {28'd0, ovf_v}, 32'd0);
                check("reset result_a", {8'd0, res_a}, 32'd0);
                check("reset result_b", {28'd0, res_b}, 32'd0);
                cyc(1);
                rst = 1'b0;
                ro_period = 10;
                cyc(5);
                check("idle busy", {28'd0, busy_v}, 32'd0);

                // Basic count: 100-cycle window, period 10 -> 10.
                exp_q.push_back('{dut: 2'd0, res: 24'd10, ovf: 1'b0});
                pulse_start(0);
                wait_valid(0, 300, c, b);
                check("basic latency", c, 103);
                check("basic busy cycles", b, 102);
                check("basic busy after", {31'd0, busy_v[0]}, 32'd0);
                @(negedge clk);
                check("basic valid one cycle", {31'd0, rv_v[0]}, 32'd0);

                // Saturation on 4-bit counter, then static input.
                ro_period = 4;
                exp_q.push_back('{dut: 2'd1, res: 24'd15, ovf: 1'b1});
                pulse_start(1);
                wait_valid(1, 300, c, b);
                ro_period = 0;
                cyc(6);
                exp_q.push_back('{dut: 2'd1, res: 24'd0, ovf: 1'b0});
                pulse_start(1);
                wait_valid(1, 300, c, b);
                check("static ovf", {31'd0, ovf_v[1]}, 32'd0);

                // Continuous: 50-cycle windows tile exactly.
                ro_period = 10;
                cyc(5);
                repeat (3) exp_q.push_back('{dut: 2'd2, res: 24'd5, ovf: 1'b0});
                continuous = 1'b1;
                pulse_start(2);
                wait_valid(2, 200, c, b);
                check("cont first latency", c, 53);
                wait_valid(2, 200, c, b);
                check("cont gap 1", c, 50);
                check("cont busy held", b, 50);
                continuous = 1'b0;
                wait_valid(2, 200, c, b);
                check("cont gap 2", c, 50);
                check("cont last busy", b, 49);
                @(negedge clk);
                check("cont idle after", {31'd0, busy_v[2]}, 32'd0);

                // Start while busy does not restart the window.
                cyc(3);
                exp_q.push_back('{dut: 2'd0, res: 24'd10, ovf: 1'b0});
                pulse_start(0);
                cyc(10); start_v[0] = 1'b1;
                cyc(1);  start_v[0] = 1'b0;
                cyc(9);  start_v[0] = 1'b1;
                cyc(1);  start_v[0] = 1'b0;
                wait_valid(0, 300, c, b);
                check("restart ignored", c, 82);

                // Abort at window cycle 30.
                cyc(3);
                pulse_start(0);
                cyc(32); abort = 1'b1;
                cyc(1);  abort = 1'b0;
                check("abort idle", {31'd0, busy_v[0]}, 32'd0);
                count_valid(0, 120, v);
                check("abort no valid", v, 0);
                check("abort result held", {8'd0, res_a}, 32'd10);

                // Abort on the final window cycle.
                ro_period = 4;
                cyc(3);
                pulse_start(0);
                cyc(101); abort = 1'b1;
                cyc(1);   abort = 1'b0;
                count_valid(0, 20, v);
                check("final abort no valid", v, 0);
                check("final abort result held", {8'd0, res_a}, 32'd10);
                ro_period = 10;

                // Async reset at window cycle 40.
                cyc(3);
                pulse_start(0);
                cyc(42);
                rst = 1'b1;
                #1;
                check("mid reset busy", {31'd0, busy_v[0]}, 32'd0);
                check("mid reset result", {8'd0, res_a}, 32'd0);
                check("mid reset valid", {31'd0, rv_v[0]}, 32'd0);
                cyc(1);
                rst = 1'b0;
                cyc(3);
                exp_q.push_back('{dut: 2'd0, res: 24'd10, ovf: 1'b0});
                pulse_start(0);
                wait_valid(0, 300, c, b);
                check("post reset latency", c, 103);

                // One-cycle window: rise lands on it, then no rise.
                ro_period = -1;
                manual = 1'b0;
                cyc(5);
                exp_q.push_back('{dut: 2'd3, res: 24'd1, ovf: 1'b0});
                pulse_start(3);
                manual = 1'b1;
                wait_valid(3, 20, c, b);
                check("gate1 latency", c, 4);
                manual = 1'b0;
                cyc(5);
                exp_q.push_back('{dut: 2'd3, res: 24'd0, ovf: 1'b0});
                pulse_start(3);
                wait_valid(3, 20, c, b);

                cyc(5);
                check("scoreboard drained", exp_q.size(), 0);
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Gated edge counter that measures a ring-oscillator-derived signal against the board clock ICE_CLK.
- Sits directly downstream of the ring oscillator. It consumes that oscillator's divided output, e.g. a counter bit of the free-running ring, as an asynchronous input `ro_div`.
- It counts rising edges of `ro_div` over a fixed window of GATE_CYCLES ICE_CLK cycles and reports the count.
- Intended for PUF/process-variation characterisation and LED/UART reporting stages.

Parameters:
- GATE_CYCLES, 12000000: length of the measurement window in ICE_CLK cycles. Legal range is 1 to 2^32-1.
- COUNT_W, 24: width of the edge counter and `result`.
- SYNC_STAGES, 2: depth of the `ro_div` synchroniser. Minimum 2.

Ports:
- ICE_CLK  input  1  sole clock.
- rst  input  1  asynchronous reset, active-high.
- ro_div  input  1  divided ring-oscillator signal. Asynchronous to ICE_CLK. Its frequency must be below ICE_CLK/4.
- start  input  1  one-cycle request to begin a measurement. Ignored while `busy`.
- continuous  input  1  when 1, a new window begins immediately after each completed window.
- abort  input  1  cancels any arming or measurement in progress.
- busy  output  1  high in ARM and MEASURE.
- result  output  COUNT_W  edge count of the last completed window.
- result_valid  output  1  one-cycle pulse when `result` updates.
- overflow  output  1  the last completed window saturated the counter. Valid alongside `result`.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE.
  - The synchroniser flops, the edge-detect flop, the gate counter, the edge counter, `result`, `result_valid` and `overflow` are all 0.
  - `busy` is 0.
- Synchroniser and edge detect:
  - `ro_div` passes through SYNC_STAGES flops, then one more flop `s_prev`.
  - `rise = s & ~s_prev` is evaluated every cycle in every state.
- IDLE:
  - `start`=1 with `abort`=0 moves to ARM and loads the arm counter with SYNC_STAGES-1.
  - `busy` goes high on the cycle after `start`.
- ARM:
  - Lasts exactly SYNC_STAGES cycles to flush stale synchroniser contents. `rise` is ignored.
  - Exits to MEASURE with the gate counter = GATE_CYCLES-1 and the edge counter = 0.
- MEASURE:
  - Each cycle in MEASURE is one window cycle, so the window is exactly GATE_CYCLES cycles.
  - On each cycle with `rise`=1, the edge counter increments, saturating at 2^COUNT_W-1. Any attempted increment past saturation sets the internal overflow flag for this window.
  - The gate counter decrements each cycle.
  - The cycle with gate counter = 0 is the final window cycle, and a `rise` on it is counted.
  - On the clock edge ending the final cycle:
    - `result` takes the final count, including that last rise.
    - `overflow` takes the internal flag.
    - `result_valid` is 1 for exactly the next cycle.
    - If `continuous`=1 (sampled on the final cycle), the state re-enters MEASURE directly with counters reloaded. ARM is skipped and there is no gap cycle, so consecutive windows tile exactly.
    - Otherwise the state goes to IDLE.
- Outputs between windows:
  - `result` and `overflow` hold until the next completion.
  - They are not cleared by `start` or `abort`.
- abort:
  - In ARM or MEASURE, the state goes to IDLE on the next edge. No `result_valid` is generated and `result` is unchanged.
  - `abort` has priority over window completion, over the `continuous` restart and over `start`.
- start while busy: ignored. It does not restart the window.
- start on the `result_valid` cycle with `continuous`=0 (state IDLE): accepted normally.
- Reset mid-operation: immediate return to the reset state. The partial count is discarded and `result` clears to 0.
- GATE_CYCLES=1: the window is one cycle, so `result` is 0 or 1.
- Gate and arm counter widths are sized by $clog2 from the parameters. No wrap-around is possible because counters reload at every window start.

Test Plan:
- Basic count: GATE_CYCLES=100, ro_div square wave of period 10 cycles, one start pulse -> single `result_valid` pulse with `result`=10, `overflow`=0, `busy` low afterwards. Measure the exact number of window cycles in MEASURE = 100.
- Saturation: COUNT_W=4, GATE_CYCLES=100, ro_div period 4 -> `result`=15, `overflow`=1. A following run with a static ro_div -> `result`=0, `overflow`=0.
- Continuous: GATE_CYCLES=50, period 10, continuous=1 -> `result_valid` pulses exactly 50 cycles apart, each with `result`=5, and `busy` never drops. Deassert continuous -> the last window completes, then IDLE.
- Abort and start-while-busy: start, repeated start pulses mid-window (no restart), then abort at window cycle 30 -> no `result_valid`, `result` retains its previous value, IDLE next cycle. Also assert abort on the final window cycle -> completion suppressed.
- Async reset mid-MEASURE: rst pulse for one cycle at window cycle 40 -> all outputs 0 immediately. A following start yields a full, correct count.
- Edge at window boundary: GATE_CYCLES=1, ro_div driven so a synchronised rise lands on the single window cycle -> `result`=1. The same run with no rise -> `result`=0.
